motoro3_step_scheduler: RTL and testbench
=========================================

MOTORO3_STEP_SCHEDULER -- requirements
Module: motoro3_step_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, 10 MHz system clock; all state updates on rising edge.
REQ-002 SHALL have port nRst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port en, input, 1, run request; 1 = spin, 0 = stop.
REQ-004 SHALL have port m3r_stepLen, input, 25, commutation step period in clk cycles.
REQ-005 SHALL have port m3r_pwmLenStart, input, 12, soft-start initial PWM length.
REQ-006 SHALL have port m3r_pwmLenTarget, input, 12, final PWM length.
REQ-007 SHALL have port m3r_rampInc, input, 8, PWM length increment per step during ramp.
REQ-008 SHALL have port m3r_dir, input, 1, rotation direction; 0 = forward, 1 = reverse.
REQ-009 SHALL have port m3cnt, output, 25, in-step cycle counter.
REQ-010 SHALL have port m3cntLast1, output, 1, one-cycle pulse on the last cycle of each step.
REQ-011 SHALL have port m3step, output, 3, commutation step index, 0..5.
REQ-012 SHALL have port m3r_pwmLenWant, output, 12, PWM length fed to the PWM generator.
REQ-013 SHALL have port running, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RAMP, RUN.
REQ-015 SHALL leave IDLE only when en=1; next state RAMP, or RUN when REQ-022 applies.
REQ-016 SHALL latch stepLenL = max(m3r_stepLen, 2) on IDLE exit and at every step boundary (cycle where m3cntLast1=1).
REQ-017 SHALL count m3cnt 0..stepLenL-1 while not IDLE, wrapping to 0 after stepLenL-1.
REQ-018 SHALL drive m3cntLast1 registered and high exactly while m3cnt == stepLenL-1; one pulse per step.
REQ-019 SHALL advance m3step at each step boundary: +1 mod 6 when m3r_dir=0, -1 with 0->5 wrap when m3r_dir=1; m3r_dir sampled at the boundary.
REQ-020 SHALL load m3r_pwmLenWant = m3r_pwmLenStart on IDLE->RAMP, with m3cnt=0, m3step=0.
REQ-021 SHALL in RAMP, at each step boundary, set pwmLenWant = min(pwmLenWant + rampInc, target) using 13-bit sum, no wrap; enter RUN in the same cycle the value equals target.
REQ-022 SHALL go directly to RUN with pwmLenWant = target when start >= target or rampInc = 0.
REQ-023 SHALL in RUN, at each step boundary, reload pwmLenWant = m3r_pwmLenTarget; no update mid-step.
REQ-024 SHALL on en=0 in any state go to IDLE next cycle: m3cnt=0, m3cntLast1=0, m3step=0, pwmLenWant=0, running=0; an en=0 coinciding with a boundary overrides the boundary update.
REQ-025 SHALL treat m3r_stepLen changes mid-step as invisible until the next boundary.

Reset
REQ-026 SHALL on nRst=0 asynchronously force state IDLE, m3cnt=0, m3cntLast1=0, m3step=0, m3r_pwmLenWant=0, running=0, stepLenL=2.
REQ-027 SHALL after nRst release stay in IDLE until en=1 is sampled; reset mid-ramp discards ramp progress.

Structure
REQ-028 SHALL place state encoding (IDLE=0, RAMP=1, RUN=2), step count 6, min step length 2 in shared package motoro3_pkg.
REQ-029 SHALL use one sub-module motoro3_ramp_sat (12-bit saturating add-and-clamp, combinational); step counter and FSM stay in the top.

Verification
REQ-030 SHALL verify: reset, en=1, stepLen=10, start=100, target=130, inc=10 -> m3cntLast1 every 10 clk; pwmLenWant 100,110,120,130; RUN entered at 3rd boundary.
REQ-031 SHALL verify: dir=0 for 7 steps then dir=1 -> m3step 0,1,2,3,4,5,0,1 then 0,5,4.
REQ-032 SHALL verify: stepLen=0 and stepLen=1 -> period 2 clk, m3cntLast1 every 2nd cycle.
REQ-033 SHALL verify: start=4000, target=4095, inc=255 -> pwmLenWant 4000 then 4095, no wrap to low values.
REQ-034 SHALL verify: en=0 on the same cycle as m3cntLast1 in RAMP -> next cycle all outputs 0, m3step not advanced.
REQ-035 SHALL verify: nRst asserted mid-step (m3cnt=5) -> outputs 0 immediately; after release with en=1, ramp restarts from start.

Source files
------------

// File: rtl/motoro3_pkg.sv
// motoro3_pkg: shared state encoding, step constants and small step helpers
package motoro3_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2} m3State_t;
  localparam int STEP_COUNT = 6;
  localparam logic [24:0] MIN_STEP_LEN = 25'd2;
  function automatic logic [24:0] clampStepLen(input logic [24:0] len);
    return (len < MIN_STEP_LEN) ? MIN_STEP_LEN : len;
  endfunction
  function automatic logic [2:0] advanceStep(input logic [2:0] step, input logic dir);
    return dir ? ((step == 3'd0) ? 3'(STEP_COUNT - 1) : step - 3'd1)
               : ((step == 3'(STEP_COUNT - 1)) ? 3'd0 : step + 3'd1);
  endfunction
endpackage

// File: rtl/motoro3_ramp_sat.sv
// motoro3_ramp_sat: 12-bit add-and-clamp, the sum is carried in 13 bits so it never wraps
module motoro3_ramp_sat (
  input  logic [11:0] cur,
  input  logic [7:0]  inc,
  input  logic [11:0] lim,
  output logic [11:0] res
);
  logic [12:0] sum;
  assign sum = {1'b0, cur} + {5'd0, inc};
  assign res = (sum > {1'b0, lim}) ? lim : sum[11:0];
endmodule

// File: rtl/motoro3_step_scheduler.sv
// motoro3_step_scheduler: six-step commutation timer with soft-start PWM ramp
module motoro3_step_scheduler
  import motoro3_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        en,
  input  logic [24:0] m3r_stepLen,
  input  logic [11:0] m3r_pwmLenStart,
  input  logic [11:0] m3r_pwmLenTarget,
  input  logic [7:0]  m3r_rampInc,
  input  logic        m3r_dir,
  output logic [24:0] m3cnt,
  output logic        m3cntLast1,
  output logic [2:0]  m3step,
  output logic [11:0] m3r_pwmLenWant,
  output logic        running
);
  m3State_t state, stateNext;
  logic [24:0] stepLenL, stepLenNext, cntNext;
  logic [2:0] stepNext;
  logic [11:0] pwmNext, satOut;
  logic lastNext, direct;
  motoro3_ramp_sat uSat (
    .cur(m3r_pwmLenWant),
    .inc(m3r_rampInc),
    .lim(m3r_pwmLenTarget),
    .res(satOut)
  );
  assign direct = (m3r_pwmLenStart >= m3r_pwmLenTarget) || (m3r_rampInc == 8'd0);
  assign running = (state != IDLE);
  // state and output registers; reset drops everything back to an idle, zeroed motor
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      m3cnt <= '0;
      m3cntLast1 <= 1'b0;
      m3step <= '0;
      m3r_pwmLenWant <= '0;
      stepLenL <= MIN_STEP_LEN;
    end else begin
      state <= stateNext;
      m3cnt <= cntNext;
      m3cntLast1 <= lastNext;
      m3step <= stepNext;
      m3r_pwmLenWant <= pwmNext;
      stepLenL <= stepLenNext;
    end
  end
  // next state: stop wins over everything, then start, then step boundary, else count within the step
  always_comb begin
    stateNext = state;
    cntNext = m3cnt;
    lastNext = 1'b0;
    stepNext = m3step;
    pwmNext = m3r_pwmLenWant;
    stepLenNext = stepLenL;
    if (!en) begin
      stateNext = IDLE;
      cntNext = '0;
      stepNext = '0;
      pwmNext = '0;
    end else if (state == IDLE) begin
      stateNext = direct ? RUN : RAMP;
      cntNext = '0;
      stepNext = '0;
      pwmNext = direct ? m3r_pwmLenTarget : m3r_pwmLenStart;
      stepLenNext = clampStepLen(m3r_stepLen);
    end else if (m3cntLast1) begin
      cntNext = '0;
      stepLenNext = clampStepLen(m3r_stepLen);
      stepNext = advanceStep(m3step, m3r_dir);
      pwmNext = (state == RAMP) ? satOut : m3r_pwmLenTarget;
      stateNext = (state == RAMP && satOut == m3r_pwmLenTarget) ? RUN : state;
    end else begin
      cntNext = m3cnt + 25'd1;
      lastNext = (m3cnt + 25'd1 == stepLenL - 25'd1);
    end
  end
endmodule

// File: tb/tb_motoro3_step_scheduler.sv
// tb_motoro3_step_scheduler: vector table, corner sequences and randomized runs against a closed-form model
module tb_motoro3_step_scheduler;
  logic clk, nRst, en, dir, last, running;
  logic [24:0] stepLen, cnt;
  logic [11:0] pwmStart, pwmTarget, pwmWant;
  logic [7:0] rampInc;
  logic [2:0] step;
  int nChecks = 0;
  int nFail = 0;

  typedef struct {
    int sl, st, tg, inc, d, k, eCnt, eLast, eStep, ePwm;
  } vec_t;

  motoro3_step_scheduler dut (
    .clk(clk), .nRst(nRst), .en(en),
    .m3r_stepLen(stepLen), .m3r_pwmLenStart(pwmStart), .m3r_pwmLenTarget(pwmTarget),
    .m3r_rampInc(rampInc), .m3r_dir(dir),
    .m3cnt(cnt), .m3cntLast1(last), .m3step(step), .m3r_pwmLenWant(pwmWant), .running(running)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOuts(input string tag, input int c, input int l, input int s, input int p, input int r);
    chk({tag, ".cnt"}, int'(cnt), c);
    chk({tag, ".last"}, int'(last), l);
    chk({tag, ".step"}, int'(step), s);
    chk({tag, ".pwm"}, int'(pwmWant), p);
    chk({tag, ".running"}, int'(running), r);
  endtask

  task automatic checkIdle(input string tag);
    checkOuts(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setCfg(input int sl, input int st, input int tg, input int inc, input int d);
    stepLen = 25'(sl);
    pwmStart = 12'(st);
    pwmTarget = 12'(tg);
    rampInc = 8'(inc);
    dir = d[0];
  endtask

  // stop for one cycle, then enable; returns at cycle index k=0 of the run
  task automatic startRun();
    en = 1'b0;
    cycles(1);
    en = 1'b1;
    cycles(1);
  endtask

  // closed-form expectation for cycle k after enable with constant configuration
  task automatic model(input int sl, input int st, input int tg, input int inc, input int d, input int k,
                       output int c, output int l, output int s, output int p);
    int len, idx;
    len = (sl < 2) ? 2 : sl;
    idx = k / len;
    c = k % len;
    l = (c == len - 1) ? 1 : 0;
    s = d ? (6 - idx % 6) % 6 : idx % 6;
    if (st >= tg || inc == 0) p = tg;
    else p = (st + idx * inc > tg) ? tg : st + idx * inc;
  endtask

  initial begin
    vec_t tbl[15];
    int expSeq[10];
    int c, l, s, p, sl, st, tg, inc, d;
    tbl[0]  = '{10, 100, 130, 10, 0, 0, 0, 0, 0, 100};
    tbl[1]  = '{10, 100, 130, 10, 0, 9, 9, 1, 0, 100};
    tbl[2]  = '{10, 100, 130, 10, 0, 10, 0, 0, 1, 110};
    tbl[3]  = '{10, 100, 130, 10, 0, 29, 9, 1, 2, 120};
    tbl[4]  = '{10, 100, 130, 10, 0, 30, 0, 0, 3, 130};
    tbl[5]  = '{10, 100, 130, 10, 0, 55, 5, 0, 5, 130};
    tbl[6]  = '{0, 5, 50, 3, 1, 1, 1, 1, 0, 5};
    tbl[7]  = '{0, 5, 50, 3, 1, 2, 0, 0, 5, 8};
    tbl[8]  = '{1, 5, 50, 3, 0, 5, 1, 1, 2, 11};
    tbl[9]  = '{7, 4000, 4095, 255, 0, 6, 6, 1, 0, 4000};
    tbl[10] = '{7, 4000, 4095, 255, 0, 7, 0, 0, 1, 4095};
    tbl[11] = '{7, 4000, 4095, 255, 0, 21, 0, 0, 3, 4095};
    tbl[12] = '{4, 200, 100, 5, 1, 0, 0, 0, 0, 100};
    tbl[13] = '{4, 200, 100, 5, 1, 4, 0, 0, 5, 100};
    tbl[14] = '{4, 50, 100, 0, 0, 5, 1, 0, 1, 100};
    expSeq = '{1, 2, 3, 4, 5, 0, 1, 0, 5, 4};

    nRst = 1'b0;
    en = 1'b0;
    setCfg(0, 0, 0, 0, 0);
    cycles(3);
    checkIdle("reset");
    nRst = 1'b1;
    cycles(2);
    checkIdle("idle_after_reset");

    for (int i = 0; i < 15; i++) begin
      setCfg(tbl[i].sl, tbl[i].st, tbl[i].tg, tbl[i].inc, tbl[i].d);
      startRun();
      cycles(tbl[i].k);
      checkOuts($sformatf("vec%0d", i), tbl[i].eCnt, tbl[i].eLast, tbl[i].eStep, tbl[i].ePwm, 1);
    end

    setCfg(3, 0, 10, 1, 0);
    startRun();
    chk("dir.start", int'(step), 0);
    for (int j = 0; j < 10; j++) begin
      if (j == 7) dir = 1'b1;
      cycles(3);
      chk($sformatf("dir.step%0d", j), int'(step), expSeq[j]);
    end

    setCfg(4, 10, 100, 10, 0);
    startRun();
    cycles(7);
    checkOuts("stop_pre", 3, 1, 1, 20, 1);
    en = 1'b0;
    cycles(1);
    checkIdle("stop_on_boundary");
    en = 1'b1;
    cycles(1);
    checkOuts("restart", 0, 0, 0, 10, 1);

    setCfg(10, 100, 130, 10, 0);
    startRun();
    cycles(15);
    checkOuts("rst_pre", 5, 0, 1, 110, 1);
    nRst = 1'b0;
    #1;
    checkIdle("async_reset");
    cycles(1);
    checkIdle("held_reset");
    nRst = 1'b1;
    cycles(1);
    checkOuts("rst_restart", 0, 0, 0, 100, 1);
    cycles(10);
    checkOuts("rst_step1", 0, 0, 1, 110, 1);

    setCfg(5, 0, 100, 1, 0);
    startRun();
    cycles(1);
    stepLen = 25'd8;
    cycles(3);
    checkOuts("len_old", 4, 1, 0, 0, 1);
    cycles(1);
    checkOuts("len_boundary", 0, 0, 1, 1, 1);
    cycles(7);
    checkOuts("len_new", 7, 1, 1, 1, 1);
    cycles(1);
    checkOuts("len_next", 0, 0, 2, 2, 1);

    for (int r = 0; r < 6; r++) begin
      sl = int'($urandom_range(0, 12));
      st = int'($urandom_range(0, 4095));
      tg = int'($urandom_range(0, 4095));
      inc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      d = int'($urandom_range(0, 1));
      if (r % 2 == 0 && st > tg) begin
        c = st;
        st = tg;
        tg = c;
      end
      if (r % 2 == 0 && inc == 0) inc = 1;
      setCfg(sl, st, tg, inc, d);
      startRun();
      for (int k = 0; k < 60; k++) begin
        if (k > 0) cycles(1);
        model(sl, st, tg, inc, d, k, c, l, s, p);
        checkOuts($sformatf("rnd%0d.k%0d", r, k), c, l, s, p, 1);
      end
      en = 1'b0;
      cycles(1);
      checkIdle($sformatf("rnd%0d.stop", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
